// File: rtl/mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_arbiter_if
//   Bus bundle between two requesting ports (A = instruction fetch,
//   B = data access), the arbiter, and an asynchronous-handshake memory.
//
//   Requester side, per port x in {a, b}:
//     x_req    requester -> arbiter   request, held high until x_ack
//     x_rw     requester -> arbiter   1 = read, 0 = write
//     x_addr   requester -> arbiter   address
//     x_wdata  requester -> arbiter   write data
//     x_ack    arbiter -> requester   one-cycle completion pulse
//     x_rdata  arbiter -> requester   read data, valid from x_ack onward
//   err          arbiter -> requester   one-cycle pulse with the ack on timeout
//
//   Memory side:
//     mem_en       arbiter -> memory  enable, memory acts on its rising edge
//     mem_rw       arbiter -> memory  1 = read, 0 = write
//     mem_mar      arbiter -> memory  address
//     mem_mdr_out  arbiter -> memory  write data
//     mem_mdr_in   memory -> arbiter  read data
//     mem_mfc      memory -> arbiter  memory-function-complete (asynchronous)
//
//   Modports: slave = the arbiter, master = the environment around it.
// -----------------------------------------------------------------------------
interface mem_arbiter_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 16
);
   logic              a_req;
   logic              a_rw;
   logic [ADDR_W-1:0] a_addr;
   logic [DATA_W-1:0] a_wdata;
   logic              a_ack;
   logic [DATA_W-1:0] a_rdata;

   logic              b_req;
   logic              b_rw;
   logic [ADDR_W-1:0] b_addr;
   logic [DATA_W-1:0] b_wdata;
   logic              b_ack;
   logic [DATA_W-1:0] b_rdata;

   logic              err;

   logic              mem_en;
   logic              mem_rw;
   logic [ADDR_W-1:0] mem_mar;
   logic [DATA_W-1:0] mem_mdr_out;
   logic [DATA_W-1:0] mem_mdr_in;
   logic              mem_mfc;

   modport slave (
      input  a_req, a_rw, a_addr, a_wdata,
      output a_ack, a_rdata,
      input  b_req, b_rw, b_addr, b_wdata,
      output b_ack, b_rdata,
      output err,
      output mem_en, mem_rw, mem_mar, mem_mdr_out,
      input  mem_mdr_in, mem_mfc
   );

   modport master (
      output a_req, a_rw, a_addr, a_wdata,
      input  a_ack, a_rdata,
      output b_req, b_rw, b_addr, b_wdata,
      input  b_ack, b_rdata,
      input  err,
      input  mem_en, mem_rw, mem_mar, mem_mdr_out,
      output mem_mdr_in, mem_mfc
   );
endinterface

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Round-robin arbiter granting one of two ports (A, B) access to a single
//   memory with an asynchronous enable / function-complete handshake.
//
//   A transaction walks IDLE -> ISSUE -> RELEASE -> DONE -> IDLE:
//     IDLE     pick a port, latch its rw/addr/wdata onto the memory bus
//     ISSUE    mem_en high, wait for synchronized MFC to rise
//     RELEASE  mem_en low, wait for synchronized MFC to fall
//     DONE     one-cycle ack to the granted port (plus err on timeout)
//   A wait counter aborts ISSUE or RELEASE into DONE with err after TIMEOUT.
//
//   Ports:
//     clk    single clock, rising edge
//     reset  asynchronous, active-high
//     bus    mem_arbiter_if.slave (requester ports A/B, err, memory bus)
//
//   Parameter:
//     TIMEOUT  cycles of wait counter per MFC edge before abort (8-bit)
// -----------------------------------------------------------------------------
module mem_arbiter #(
   parameter logic [7:0] TIMEOUT = 8'd255
) (
   input  logic           clk,
   input  logic           reset,
   mem_arbiter_if.slave   bus
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      RELEASE = 2'd2,
      DONE    = 2'd3
   } state_t;

   state_t     state;
   state_t     state_nx;

   logic       mfc_p0;
   logic       mfc_p1;
   logic       mfc_s;

   logic [7:0] wait_cnt;
   logic       gnt_b;        // current transaction belongs to port B
   logic       last_b;       // most recent grant went to port B

   logic       grant;
   logic       grant_b_nx;
   logic       capture;
   logic       timeout_hit;
   logic       cnt_clr;
   logic       in_wait;

   // ---- MFC synchronizer: two flops, FSM only ever sees mfc_s ----
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mfc_p0 <= 1'b0;
         mfc_p1 <= 1'b0;
      end else begin
         mfc_p0 <= bus.mem_mfc;
         mfc_p1 <= mfc_p0;
      end
   end

   assign mfc_s = mfc_p1;

   // ---- FSM state register ----
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // ---- FSM next-state and strobes ----
   always_comb begin
      state_nx    = state;
      grant       = 1'b0;
      grant_b_nx  = 1'b0;
      capture     = 1'b0;
      timeout_hit = 1'b0;

      unique case (state)
         IDLE: begin
            if (bus.a_req || bus.b_req) begin
               grant = 1'b1;
               // B wins when it is alone, or when both ask and A went last.
               grant_b_nx = bus.b_req && (!bus.a_req || !last_b);
               state_nx   = ISSUE;
            end
         end
         ISSUE: begin
            // A completing handshake takes priority over a coincident timeout.
            if (mfc_s) begin
               capture  = bus.mem_rw;
               state_nx = RELEASE;
            end else if (wait_cnt == TIMEOUT) begin
               timeout_hit = 1'b1;
               state_nx    = DONE;
            end
         end
         RELEASE: begin
            if (!mfc_s) begin
               state_nx = DONE;
            end else if (wait_cnt == TIMEOUT) begin
               timeout_hit = 1'b1;
               state_nx    = DONE;
            end
         end
         DONE: begin
            // Always pass through IDLE so back-to-back grants get a gap.
            state_nx = IDLE;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase

      in_wait = (state == ISSUE) || (state == RELEASE);
      cnt_clr = (state_nx != state) &&
                ((state_nx == ISSUE) || (state_nx == RELEASE));
   end

   // ---- Control registers: counter, grant tracking, strobes ----
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wait_cnt   <= 8'd0;
         gnt_b      <= 1'b0;
         last_b     <= 1'b1;    // first contended grant after reset goes to A
         bus.mem_en <= 1'b0;
         bus.a_ack  <= 1'b0;
         bus.b_ack  <= 1'b0;
         bus.err    <= 1'b0;
      end else begin
         if (cnt_clr) begin
            wait_cnt <= 8'd0;
         end else if (in_wait) begin
            wait_cnt <= wait_cnt + 8'd1;
         end

         if (grant) begin
            gnt_b  <= grant_b_nx;
            last_b <= grant_b_nx;
         end

         // Registered from next state so mem_en is a clean flop output that
         // is high exactly for the ISSUE cycles.
         bus.mem_en <= (state_nx == ISSUE);
         bus.a_ack  <= (state_nx == DONE) && !gnt_b;
         bus.b_ack  <= (state_nx == DONE) &&  gnt_b;
         bus.err    <= timeout_hit;
      end
   end

   // ---- Datapath registers: memory bus latch and read-data capture ----
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bus.mem_rw      <= 1'b0;
         bus.mem_mar     <= '0;
         bus.mem_mdr_out <= '0;
         bus.a_rdata     <= '0;
         bus.b_rdata     <= '0;
      end else begin
         // Bus fields are written only at the grant, so they hold steady
         // through ISSUE, RELEASE and DONE.
         if (grant) begin
            bus.mem_rw      <= grant_b_nx ? bus.b_rw    : bus.a_rw;
            bus.mem_mar     <= grant_b_nx ? bus.b_addr  : bus.a_addr;
            bus.mem_mdr_out <= grant_b_nx ? bus.b_wdata : bus.a_wdata;
         end

         // Only the granted port's rdata moves, and only on a completed read.
         if (capture) begin
            if (gnt_b) begin
               bus.b_rdata <= bus.mem_mdr_in;
            end else begin
               bus.a_rdata <= bus.mem_mdr_in;
            end
         end
      end
   end

endmodule
